// File: rtl/asic_spi_responder_if.sv
// Link and core-side signal bundle for asic_spi_responder; slave = responder, master = FPGA/core side.
// With SPI_RESP_WORD_CNT_EN defined the bundle also carries the 16-bit link word counters.
interface asic_spi_responder_if #(
    parameter int DATA_W = 128
);
    logic              I_spi_cs_n;
    logic              I_spi_sck;
    logic              I_OE_req;
    logic [DATA_W-1:0] I_spi_data;
    logic [DATA_W-1:0] O_spi_data;
    logic              O_spi_oe;
    logic              O_config_req;
    logic              O_switch_rdwr;
    logic              O_near_full;
    logic              I_core_rd_req;
    logic              I_rx_rd;
    logic [DATA_W-1:0] O_rx_data;
    logic              O_rx_empty;
    logic              I_tx_wr;
    logic [DATA_W-1:0] I_tx_data;
    logic              O_tx_full;
    logic              O_err;
`ifdef SPI_RESP_WORD_CNT_EN
    logic [15:0]       O_rx_word_cnt;
    logic [15:0]       O_tx_word_cnt;
`endif

    modport slave (
        input  I_spi_cs_n, I_spi_sck, I_OE_req, I_spi_data,
        input  I_core_rd_req, I_rx_rd, I_tx_wr, I_tx_data,
        output O_spi_data, O_spi_oe, O_config_req, O_switch_rdwr, O_near_full,
        output O_rx_data, O_rx_empty, O_tx_full, O_err
`ifdef SPI_RESP_WORD_CNT_EN
        , output O_rx_word_cnt, O_tx_word_cnt
`endif
    );

    modport master (
        output I_spi_cs_n, I_spi_sck, I_OE_req, I_spi_data,
        output I_core_rd_req, I_rx_rd, I_tx_wr, I_tx_data,
        input  O_spi_data, O_spi_oe, O_config_req, O_switch_rdwr, O_near_full,
        input  O_rx_data, O_rx_empty, O_tx_full, O_err
`ifdef SPI_RESP_WORD_CNT_EN
        , input O_rx_word_cnt, O_tx_word_cnt
`endif
    );
endinterface

// File: rtl/asic_spi_responder.sv
// ASIC-side responder for the parallel SPI-style link: RX config FIFO, TX result FIFO and burst FSM.
// Optional macro SPI_RESP_WORD_CNT_EN adds 16-bit RX-push / TX-pop link word counters.
module asic_spi_responder #(
    parameter int DATA_W       = 128,
    parameter int RX_DEPTH     = 8,
    parameter int TX_DEPTH     = 8,
    parameter int RX_BURST     = 4,
    parameter int TX_BURST     = 4,
    parameter int NEAR_FULL_TH = 6
) (
    input logic                  I_clk,
    input logic                  I_rst,
    asic_spi_responder_if.slave  bus
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;
    localparam int BW    = $clog2(((RX_BURST > TX_BURST) ? RX_BURST : TX_BURST) + 1);

    localparam logic [RX_CW-1:0] RX_DEPTH_C = RX_CW'(RX_DEPTH);
    localparam logic [RX_CW-1:0] RX_BURST_C = RX_CW'(RX_BURST);
    localparam logic [RX_CW-1:0] NF_TH_C    = RX_CW'(NEAR_FULL_TH);
    localparam logic [TX_CW-1:0] TX_DEPTH_C = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0] TX_BURST_C = TX_CW'(TX_BURST);
    localparam logic [BW-1:0]    RX_LAST_C  = BW'(RX_BURST - 1);
    localparam logic [BW-1:0]    TX_LAST_C  = BW'(TX_BURST - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ_RX, S_RX, S_REQ_TX, S_TX, S_WAIT_CS} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              err_q, err_d;
    logic              cs_meta_q, cs_sync_q, cs_hist_q;
    logic              sck_meta_q, sck_sync_q, sck_hist_q;
    logic              sck_rise_s, cs_rise_s, fsm_err_s, rx_push_s, tx_pop_s;
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TX_AW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d, rx_free_s;
    logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic              rx_do_push_s, rx_do_pop_s, tx_do_push_s, tx_do_pop_s;
    logic              cfg_req_q, cfg_req_d, sw_q, sw_d, oe_q, oe_d;
    logic              near_full_q, near_full_d, rx_empty_q, rx_empty_d, tx_full_q, tx_full_d;
    logic [DATA_W-1:0] spi_data_q, spi_data_d;

    assign sck_rise_s = sck_sync_q & ~sck_hist_q;
    assign cs_rise_s  = cs_sync_q & ~cs_hist_q;
    assign rx_free_s  = RX_DEPTH_C - rx_cnt_q;

    // Two-flop synchronisers plus history flop for the asynchronous link strobes
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_hist_q  <= 1'b1;
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_hist_q <= 1'b0;
        end else begin
            cs_meta_q  <= bus.I_spi_cs_n;
            cs_sync_q  <= cs_meta_q;
            cs_hist_q  <= cs_sync_q;
            sck_meta_q <= bus.I_spi_sck;
            sck_sync_q <= sck_meta_q;
            sck_hist_q <= sck_sync_q;
        end
    end

    // Burst FSM next-state; RX requests win over TX requests in IDLE
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        fsm_err_s = 1'b0;
        rx_push_s = 1'b0;
        tx_pop_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                burst_d = '0;
                if (bus.I_core_rd_req && (rx_free_s >= RX_BURST_C)) begin
                    state_d = S_REQ_RX;
                end else if (tx_cnt_q >= TX_BURST_C) begin
                    state_d = S_REQ_TX;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ_RX: begin
                if (!cs_sync_q && !bus.I_OE_req) state_d = S_RX;
                else                             state_d = S_REQ_RX;
            end
            S_RX: begin
                if (cs_rise_s) begin
                    state_d   = S_IDLE;
                    fsm_err_s = 1'b1;
                end else if (bus.I_OE_req) begin
                    state_d   = S_WAIT_CS;
                    fsm_err_s = 1'b1;
                end else if (sck_rise_s) begin
                    rx_push_s = 1'b1;
                    burst_d   = burst_q + BW'(1'b1);
                    if (burst_q == RX_LAST_C) state_d = S_WAIT_CS;
                    else                      state_d = S_RX;
                end else begin
                    state_d = S_RX;
                end
            end
            S_REQ_TX: begin
                if (!cs_sync_q && bus.I_OE_req) state_d = S_TX;
                else                            state_d = S_REQ_TX;
            end
            S_TX: begin
                if (cs_rise_s) begin
                    state_d   = S_IDLE;
                    fsm_err_s = 1'b1;
                end else if (!bus.I_OE_req) begin
                    state_d   = S_WAIT_CS;
                    fsm_err_s = 1'b1;
                end else if (sck_rise_s) begin
                    tx_pop_s = 1'b1;
                    burst_d  = burst_q + BW'(1'b1);
                    if (burst_q == TX_LAST_C) state_d = S_WAIT_CS;
                    else                      state_d = S_TX;
                end else begin
                    state_d = S_TX;
                end
            end
            S_WAIT_CS: begin
                fsm_err_s = sck_rise_s;
                if (cs_sync_q) state_d = S_IDLE;
                else           state_d = S_WAIT_CS;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a TX push into a full FIFO is only accepted alongside a pop
    always_comb begin
        rx_do_push_s = rx_push_s && (rx_cnt_q != RX_DEPTH_C);
        rx_do_pop_s  = bus.I_rx_rd && (rx_cnt_q != '0);
        tx_do_pop_s  = tx_pop_s && (tx_cnt_q != '0);
        tx_do_push_s = bus.I_tx_wr && ((tx_cnt_q != TX_DEPTH_C) || tx_do_pop_s);
        err_d        = err_q | fsm_err_s | (bus.I_tx_wr & ~tx_do_push_s);
        rx_wr_ptr_d  = rx_do_push_s ? rx_wr_ptr_q + RX_AW'(1'b1) : rx_wr_ptr_q;
        rx_rd_ptr_d  = rx_do_pop_s  ? rx_rd_ptr_q + RX_AW'(1'b1) : rx_rd_ptr_q;
        tx_wr_ptr_d  = tx_do_push_s ? tx_wr_ptr_q + TX_AW'(1'b1) : tx_wr_ptr_q;
        tx_rd_ptr_d  = tx_do_pop_s  ? tx_rd_ptr_q + TX_AW'(1'b1) : tx_rd_ptr_q;
        case ({rx_do_push_s, rx_do_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1'b1);
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1'b1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        case ({tx_do_push_s, tx_do_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1'b1);
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1'b1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // Output lookahead: registered outputs follow the state being entered, so the TX head is presented one cycle after each pop
    always_comb begin
        cfg_req_d   = (state_d == S_REQ_RX) || (state_d == S_RX);
        sw_d        = (state_d == S_REQ_TX) || (state_d == S_TX);
        oe_d        = (state_d == S_TX);
        near_full_d = (rx_cnt_d >= NF_TH_C);
        rx_empty_d  = (rx_cnt_d == '0);
        tx_full_d   = (tx_cnt_d == TX_DEPTH_C);
        if (oe_d) spi_data_d = tx_mem_q[tx_rd_ptr_d];
        else      spi_data_d = '0;
    end

    // State, pointer, counter and output registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            burst_q     <= '0;
            err_q       <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            cfg_req_q   <= 1'b0;
            sw_q        <= 1'b0;
            oe_q        <= 1'b0;
            near_full_q <= 1'b0;
            rx_empty_q  <= 1'b1;
            tx_full_q   <= 1'b0;
            spi_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            cfg_req_q   <= cfg_req_d;
            sw_q        <= sw_d;
            oe_q        <= oe_d;
            near_full_q <= near_full_d;
            rx_empty_q  <= rx_empty_d;
            tx_full_q   <= tx_full_d;
            spi_data_q  <= spi_data_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge I_clk) begin
        if (rx_do_push_s) rx_mem_q[rx_wr_ptr_q] <= bus.I_spi_data;
        if (tx_do_push_s) tx_mem_q[tx_wr_ptr_q] <= bus.I_tx_data;
    end

`ifdef SPI_RESP_WORD_CNT_EN
    logic [15:0] rx_wcnt_q, rx_wcnt_d, tx_wcnt_q, tx_wcnt_d;

    // Link word counters wrap naturally at 16 bits
    always_comb begin
        rx_wcnt_d = rx_wcnt_q + {15'd0, rx_do_push_s};
        tx_wcnt_d = tx_wcnt_q + {15'd0, tx_do_pop_s};
    end

    // Link word counter registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rx_wcnt_q <= 16'd0;
            tx_wcnt_q <= 16'd0;
        end else begin
            rx_wcnt_q <= rx_wcnt_d;
            tx_wcnt_q <= tx_wcnt_d;
        end
    end

    assign bus.O_rx_word_cnt = rx_wcnt_q;
    assign bus.O_tx_word_cnt = tx_wcnt_q;
`endif

    assign bus.O_spi_data    = spi_data_q;
    assign bus.O_spi_oe      = oe_q;
    assign bus.O_config_req  = cfg_req_q;
    assign bus.O_switch_rdwr = sw_q;
    assign bus.O_near_full   = near_full_q;
    assign bus.O_rx_data     = rx_mem_q[rx_rd_ptr_q];
    assign bus.O_rx_empty    = rx_empty_q;
    assign bus.O_tx_full     = tx_full_q;
    assign bus.O_err         = err_q;
endmodule
